// File: rtl/mem_backing_responder.sv
// Word-addressed backing store that answers each front-end request after a fixed
// programmable latency with a single-cycle mem_response pulse.
module mem_backing_responder #(
    parameter int                   MEM_WIDTH = 32,
    parameter int                   MEM_SIZE  = 256,
    parameter int                   LATENCY   = 2,
    parameter logic [MEM_WIDTH-1:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_addr,
    input  logic                 mem_read_en,
    input  logic                 mem_write_en,
    input  logic [MEM_WIDTH-1:0] mem_write_val,
    output logic [MEM_WIDTH-1:0] mem_read_val,
    output logic                 mem_response,
    output logic                 busy,
    output logic                 addr_err
);

    // state   | meaning
    // IDLE    | waiting for a read or write request
    // BUSY    | latency down-counter running on the captured request
    // RESP    | mem_response pulse; array and read data updated on entry
    // RELEASE | waiting for the front end to drop its enables

    localparam int         AW       = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;

    state_t               state, state_nxt;
    logic [3:0]           cnt;
    logic [31:0]          addr_q;
    logic [MEM_WIDTH-1:0] wdata_q;
    logic                 rd_q, wr_q;
    logic                 in_range;
    logic                 commit;
    logic [AW-1:0]        idx;

    logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

    assign in_range     = addr_q < 32'(MEM_SIZE);
    assign idx          = addr_q[AW-1:0];
    assign commit       = (state == BUSY) && (cnt == 4'd0);
    assign mem_response = (state == RESP);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_read_en || mem_write_en) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = RELEASE;
            RELEASE: if (!mem_read_en && !mem_write_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            mem_read_val <= '0;
            addr_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (mem_read_en || mem_write_en)) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_write_val;
                rd_q    <= mem_read_en;
                wr_q    <= mem_write_en;
                cnt     <= CNT_LOAD;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                if (!in_range) addr_err <= 1'b1;
                // Combined read+write returns the freshly written word.
                if (rd_q) mem_read_val <= !in_range ? ERR_DATA :
                                          wr_q      ? wdata_q  : mem[idx];
            end
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (commit && wr_q && in_range) mem[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_mem_backing_responder.sv
// Directed bench for mem_backing_responder with a transaction-level model checked
// against the DUT on every cycle.
module tb_mem_backing_responder;
    localparam int LAT = 2;
    localparam int SIZE = 256;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_read_en = 1'b0;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_write_val = 32'd0;
    logic [31:0] mem_read_val;
    logic        mem_response;
    logic        busy;
    logic        addr_err;

    mem_backing_responder #(
        .MEM_WIDTH(32), .MEM_SIZE(SIZE), .LATENCY(LAT), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_write_val(mem_write_val),
        .mem_read_val(mem_read_val), .mem_response(mem_response),
        .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_resp = 0;

    // Model: expected response cycle, busy window and the captured request
    int          resp_cyc = -1;
    int          busy_lo = 0;
    int          busy_hi = -1;
    logic        m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] exp_rv = 32'd0;
    logic        exp_err = 1'b0;
    logic [31:0] model_mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rst_n && cyc == resp_cyc) begin
            n_resp++;
            if (m_addr < SIZE) begin
                if (m_wr) model_mem[m_addr] = m_wdata;
                if (m_rd) exp_rv = model_mem[m_addr];
            end else begin
                exp_err = 1'b1;
                if (m_rd) exp_rv = ERR;
            end
        end
        chk("mem_response", {31'd0, mem_response}, {31'd0, cyc == resp_cyc});
        chk("busy", {31'd0, busy}, {31'd0, cyc >= busy_lo && cyc <= busy_hi});
        chk("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        chk("mem_read_val", mem_read_val, exp_rv);
    end

    // Called #1 after a posedge with the DUT idle; enables drop hold cycles after RESP.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input logic chg);
        int cap;
        mem_read_en = rd; mem_write_en = wr; mem_addr = addr; mem_write_val = wdata;
        cap = cyc + 1;
        m_rd = rd; m_wr = wr; m_addr = addr; m_wdata = wdata;
        resp_cyc = cap + LAT;
        busy_lo = cap;
        busy_hi = cap + LAT + 1 + hold;
        @(posedge clk); #1;
        if (chg) begin mem_addr = addr + 32'd10; mem_write_val = ~wdata; end
        while (cyc < cap + LAT + 1 + hold) begin @(posedge clk); #1; end
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int r0, cap;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 32'd20, 32'h20202020, 0, 1'b0);
        txn(1'b0, 1'b1, 32'd7,  32'h11111111, 0, 1'b0);

        // Write then read @5
        r0 = n_resp;
        txn(1'b0, 1'b1, 32'd5, 32'h12345678, 0, 1'b0);
        chk("t2_write_pulses", n_resp - r0, 1);
        chk("t2_wr_keeps_rv", mem_read_val, 32'd0);
        txn(1'b1, 1'b0, 32'd5, 32'h0, 0, 1'b0);
        chk("t2_read_val", mem_read_val, 32'h12345678);

        // Simultaneous read+write @0
        txn(1'b1, 1'b1, 32'd0, 32'hA5A5A5A5, 0, 1'b0);
        chk("t3_rw_val", mem_read_val, 32'hA5A5A5A5);
        txn(1'b1, 1'b0, 32'd0, 32'h0, 0, 1'b0);
        chk("t3_array0", mem_read_val, 32'hA5A5A5A5);

        // Out-of-range read then write
        chk("t4_err_before", {31'd0, addr_err}, 32'd0);
        txn(1'b1, 1'b0, 32'd256, 32'h0, 0, 1'b0);
        chk("t4_err_data", mem_read_val, 32'hDEADBEEF);
        chk("t4_addr_err", {31'd0, addr_err}, 32'd1);
        txn(1'b0, 1'b1, 32'd300, 32'h55555555, 0, 1'b0);
        chk("t4_err_sticky", {31'd0, addr_err}, 32'd1);
        txn(1'b1, 1'b0, 32'h0000_0100 | 32'h8000_0000, 32'h0, 0, 1'b0);
        chk("t4_hi_bits", mem_read_val, 32'hDEADBEEF);

        // Enables held 4 cycles after the pulse
        r0 = n_resp;
        txn(1'b1, 1'b0, 32'd5, 32'h0, 4, 1'b0);
        chk("t5_one_pulse", n_resp - r0, 1);
        chk("t5_idle_after", {31'd0, busy}, 32'd0);

        // Address changed during BUSY
        txn(1'b0, 1'b1, 32'd10, 32'hCAFE0001, 0, 1'b1);
        txn(1'b1, 1'b0, 32'd10, 32'h0, 0, 1'b0);
        chk("t6_addr10", mem_read_val, 32'hCAFE0001);
        txn(1'b1, 1'b0, 32'd20, 32'h0, 0, 1'b0);
        chk("t6_addr20", mem_read_val, 32'h20202020);

        // Reset mid-BUSY on a write to @7
        mem_write_en = 1'b1; mem_addr = 32'd7; mem_write_val = 32'h99999999;
        cap = cyc + 1;
        resp_cyc = -1; busy_lo = cap; busy_hi = 1 << 30;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        busy_hi = cap;
        exp_err = 1'b0;
        exp_rv = 32'd0;
        #1;
        chk("t1_rst_resp", {31'd0, mem_response}, 32'd0);
        chk("t1_rst_busy", {31'd0, busy}, 32'd0);
        chk("t1_rst_err", {31'd0, addr_err}, 32'd0);
        chk("t1_rst_rv", mem_read_val, 32'd0);
        mem_write_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 32'd7, 32'h0, 0, 1'b0);
        chk("t1_old_data", mem_read_val, 32'h11111111);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
